// File: rtl/sprot_driver.sv
// Transmit side of the start/a/b protocol: queues requests, emits start/a/b, tracks outcome.
// Define SPROT_DRV_ERR_INJECT_EN to store req_inject per entry and drop a or b on request.
module sprot_driver #(
    parameter int DEPTH   = 4,
    parameter int CNT_W   = 8,
    parameter int TIMEOUT = 8,
    parameter int STRETCH = 1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             req_valid,
    input  logic [1:0]       req_inject,
    output logic             req_ready,
    output logic             start,
    output logic             a,
    output logic             b,
    input  logic             prot_err,
    input  logic             xfer_end,
    output logic             busy,
    output logic             done,
    output logic             err,
    output logic             timeout,
    output logic [CNT_W-1:0] xfer_cnt,
    output logic [CNT_W-1:0] err_cnt
);
    localparam int AW = $clog2(DEPTH);
    localparam int TW = $clog2(TIMEOUT + 1);

    typedef enum logic [2:0] {IDLE, START, A_PH, B_PH, WAIT_END} state_t;

    state_t        state;
    logic [AW:0]   wr_ptr, rd_ptr;
    logic          empty, full, push, pop;
    logic          ph_cnt;
    logic [TW-1:0] tmr;
    logic [1:0]    cur_inj;
    logic          a_on, b_on, sampling;

    assign empty     = (wr_ptr == rd_ptr);
    assign full      = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
    assign req_ready = !full;
    assign push      = req_valid && !full;
    assign pop       = (state == IDLE) && !empty;
    assign busy      = (state != IDLE) || !empty;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + 1'b1;
            if (pop)  rd_ptr <= rd_ptr + 1'b1;
        end
    end

`ifdef SPROT_DRV_ERR_INJECT_EN
    logic [1:0] inj_mem [DEPTH];

    always_ff @(posedge clk) begin
        if (push) inj_mem[wr_ptr[AW-1:0]] <= req_inject;
    end

    always_ff @(posedge clk) begin
        if (!rst_n)   cur_inj <= 2'd0;
        else if (pop) cur_inj <= inj_mem[rd_ptr[AW-1:0]];
    end
`else
    wire unused_inject = &{1'b0, req_inject};
    assign cur_inj = 2'd0;
`endif

    // code 3 is reserved and behaves like a well-formed transfer
    assign a_on     = (cur_inj != 2'd1);
    assign b_on     = (cur_inj != 2'd2);
    assign sampling = (state == A_PH) || (state == B_PH) || (state == WAIT_END);

    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
        return (&v) ? v : v + 1'b1;
    endfunction

    // With STRETCH the A_PH->B_PH hop keeps a high, so a and b overlap for one cycle.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state    <= IDLE;
            start    <= 1'b0;
            a        <= 1'b0;
            b        <= 1'b0;
            done     <= 1'b0;
            err      <= 1'b0;
            timeout  <= 1'b0;
            ph_cnt   <= 1'b0;
            tmr      <= '0;
            xfer_cnt <= '0;
            err_cnt  <= '0;
        end else begin
            start   <= 1'b0;
            done    <= 1'b0;
            err     <= 1'b0;
            timeout <= 1'b0;
            if (xfer_end && sampling) begin
                state <= IDLE;
                a     <= 1'b0;
                b     <= 1'b0;
                done  <= !prot_err;
                err   <= prot_err;
                if (prot_err) err_cnt  <= sat_inc(err_cnt);
                else          xfer_cnt <= sat_inc(xfer_cnt);
            end else begin
                case (state)
                    IDLE: begin
                        if (!empty) begin
                            state <= START;
                            start <= 1'b1;
                        end
                    end
                    START: begin
                        state <= A_PH;
                        a     <= a_on;
                    end
                    A_PH: begin
                        state  <= B_PH;
                        ph_cnt <= 1'b0;
                        b      <= b_on;
                        if (STRETCH == 0) a <= 1'b0;
                    end
                    B_PH: begin
                        a <= 1'b0;
                        if (ph_cnt == 1'(STRETCH)) begin
                            state <= WAIT_END;
                            tmr   <= '0;
                            b     <= 1'b0;
                        end else begin
                            ph_cnt <= 1'b1;
                        end
                    end
                    WAIT_END: begin
                        if (tmr == TW'(TIMEOUT - 1)) begin
                            state   <= IDLE;
                            timeout <= 1'b1;
                            err     <= 1'b1;
                            err_cnt <= sat_inc(err_cnt);
                        end else begin
                            tmr <= tmr + 1'b1;
                        end
                    end
                    default: state <= IDLE;
                endcase
            end
        end
    end
endmodule
